// File: rtl/add_pipe_pkg.sv
// Shared constants and per-stage payload record for the pipelined adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// The stage record is sized for the widest supported adder (PIPE_MAX_W);
// instances use the low WIDTH bits and the remaining bits stay zero.
package add_pipe_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;
    localparam int PIPE_MAX_W = 64;

    // One pipeline entry: valid flag, partially built sum/cout, the carry
    // handed to the next slice, and the operands (upper slices still pending).
    typedef struct packed {
        logic                  vld;
        logic [PIPE_MAX_W-1:0] a;
        logic [PIPE_MAX_W-1:0] b;
        logic [PIPE_MAX_W-1:0] sum;
        logic [PIPE_MAX_W-1:0] cout;
        logic                  carry;
    } stage_t;

endpackage

// File: rtl/add_slice.sv
// W-bit combinational ripple-carry slice with per-bit carry outputs.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline decides when results are kept.
//
// Ports: a, b   - W-bit operand slices
//        cin    - carry into bit 0 of the slice
//        sum    - W-bit slice sum
//        cout   - per-bit carry vector, cout[W-1] feeds the next slice
module add_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic [W-1:0] cout
);

    always_comb begin
        logic c;
        c    = cin;
        sum  = '0;
        cout = '0;
        for (int i = 0; i < W; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c;
            c       = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
            cout[i] = c;
        end
    end

endmodule

// File: rtl/add_pipe_nb.sv
// Pipelined WIDTH-bit adder: STAGES slices of WIDTH/STAGES bits, carry registered between slices.
// Latency: STAGES cycles from accept to out_valid; one result per cycle when out_ready stays high.
// Backpressure: whole pipe advances only when !out_valid || out_ready; in_ready mirrors that (combinational).
//
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready + a, b, cin   - operand handshake
//        out_valid/out_ready + sum, cout, ovf - result handshake
// Optional feature: define ADD_PIPE_OVF_EN to produce the signed overflow
// flag; otherwise ovf is tied to 0. WIDTH must not exceed PIPE_MAX_W.
module add_pipe_nb
    import add_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] cout,
    output logic             ovf
);

    localparam int W = WIDTH / STAGES;

    logic   adv;
    stage_t head;

    // A single advance enable keeps every stage in lock-step, so stalls can
    // neither drop nor duplicate an entry.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Entry presented to stage 0; bubbles enter with vld = 0.
    always_comb begin
        head              = '0;
        head.vld          = in_valid;
        head.a[WIDTH-1:0] = a;
        head.b[WIDTH-1:0] = b;
        head.carry        = cin;
    end

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stg
            stage_t       src;
            stage_t       nxt;
            stage_t       q;
            logic [W-1:0] s_sum;
            logic [W-1:0] s_cout;

            if (k == 0) begin : g_first
                assign src = head;
            end else begin : g_next
                assign src = g_stg[k-1].q;
            end

            add_slice #(.W(W)) u_slice (
                .a    (src.a[k*W +: W]),
                .b    (src.b[k*W +: W]),
                .cin  (src.carry),
                .sum  (s_sum),
                .cout (s_cout)
            );

            // Lower slices and unused upper operands ride along unchanged;
            // only this stage's slice of sum/cout is filled in.
            always_comb begin
                nxt                 = src;
                nxt.sum[k*W +: W]   = s_sum;
                nxt.cout[k*W +: W]  = s_cout;
                nxt.carry           = s_cout[W-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (adv) begin
                    q <= nxt;
                end
            end
        end
    endgenerate

    assign out_valid = g_stg[STAGES-1].q.vld;
    assign sum       = g_stg[STAGES-1].q.sum[WIDTH-1:0];
    assign cout      = g_stg[STAGES-1].q.cout[WIDTH-1:0];

    // Operand copies and padding bits above WIDTH end here.
    logic unused_tail;
    assign unused_tail = ^g_stg[STAGES-1].q;

`ifdef ADD_PIPE_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    // Registered from the last stage's next-state so it lines up with sum.
    logic ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= g_stg[STAGES-1].nxt.cout[WIDTH-1] ^ g_stg[STAGES-1].nxt.cout[WIDTH-2];
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_add_pipe_nb.sv
// Self-checking bench for add_pipe_nb (WIDTH=8, STAGES=2).
// Latency/backpressure behaviour of the DUT is checked against an arithmetic reference model.
// Expected ovf depends on whether ADD_PIPE_OVF_EN is defined for the build.
module tb_add_pipe_nb;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
        logic             o;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] cout;
    logic             ovf;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    res_t got[$];
    int   got_cyc[$];
    res_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_pipe_nb #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Record every result that is handed over at the next rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            got.push_back({sum, cout, ovf});
            got_cyc.push_back(cyc);
        end
    end

    // Reference: plain integer arithmetic. Carry out of bit i is bit i+1 of
    // the sum of the operands truncated to bits [i:0] plus cin.
    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci);
        res_t   r;
        longint ux;
        longint uy;
        longint t;
        longint m;
        longint sx;
        longint sy;
        ux  = longint'(x);
        uy  = longint'(y);
        t   = ux + uy + longint'(ci);
        r.s = WIDTH'(t);
        r.c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m      = (longint'(1) << (i + 1)) - 1;
            r.c[i] = (((ux & m) + (uy & m) + longint'(ci)) >> (i + 1)) != 0;
        end
`ifdef ADD_PIPE_OVF_EN
        sx  = x[WIDTH-1] ? ux - (longint'(1) << WIDTH) : ux;
        sy  = y[WIDTH-1] ? uy - (longint'(1) << WIDTH) : uy;
        t   = sx + sy + longint'(ci);
        r.o = (t > (longint'(1) << (WIDTH - 1)) - 1) || (t < -(longint'(1) << (WIDTH - 1)));
`else
        sx  = 0;
        sy  = 0;
        r.o = 1'b0;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v);
        in_valid = v;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cin      = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_got(input string tag, input int n, input int bound);
        for (int i = 0; i < bound && got.size() < n; i++) step();
        chk(tag, 64'(got.size()), 64'(n));
    endtask

    task automatic compare_all(input string tag, input logic in_order);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) begin
                chk(tag, 64'(got[i]), 64'(exp_q[i]));
                if (in_order && i > 0)
                    chk({tag, "_cycle"}, 64'(got_cyc[i]), 64'(got_cyc[i-1] + 1));
            end
        end
    endtask

    // Directed vectors with hand-computed results.
    logic [WIDTH-1:0] ta   [3] = '{8'h0F, 8'hFF, 8'h7F};
    logic [WIDTH-1:0] tb   [3] = '{8'h01, 8'h00, 8'h01};
    logic             tc   [3] = '{1'b0, 1'b1, 1'b0};
    logic [WIDTH-1:0] ts   [3] = '{8'h10, 8'h00, 8'h80};
    logic [WIDTH-1:0] tco  [3] = '{8'h0F, 8'hFF, 8'h7F};
`ifdef ADD_PIPE_OVF_EN
    logic             tovf [3] = '{1'b0, 1'b0, 1'b1};
`else
    logic             tovf [3] = '{1'b0, 1'b0, 1'b0};
`endif

    initial begin
        int n_acc;

        // ---- reset ----
        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        chk("post_rst_out_valid", 64'(out_valid), 64'(0));
        step();
        chk("idle_out_valid", 64'(out_valid), 64'(0));

        // ---- directed vectors with latency check ----
        for (int v = 0; v < 3; v++) begin
            in_valid = 1'b1;
            a        = ta[v];
            b        = tb[v];
            cin      = tc[v];
            step();
            in_valid = 1'b0;
            for (int c = 0; c < STAGES - 1; c++) begin
                chk("dir_early_valid", 64'(out_valid), 64'(0));
                step();
            end
            chk("dir_out_valid", 64'(out_valid), 64'(1));
            chk("dir_sum", 64'(sum), 64'(ts[v]));
            chk("dir_cout", 64'(cout), 64'(tco[v]));
            chk("dir_ovf", 64'(ovf), 64'(tovf[v]));
            step();
        end
        step();

        // ---- 8 back-to-back random operand sets ----
        got.delete();
        got_cyc.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1);
            #1;
            chk("b2b_in_ready", 64'(in_ready), 64'(1));
            exp_q.push_back(model(a, b, cin));
            step();
        end
        in_valid = 1'b0;
        wait_got("b2b_count", 8, 30);
        compare_all("b2b_res", 1'b1);

        // ---- stall with full pipeline ----
        got.delete();
        got_cyc.delete();
        exp_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            drive(1'b1);
            #1;
            chk("fill_in_ready", 64'(in_ready), 64'(1));
            exp_q.push_back(model(a, b, cin));
            step();
        end
        drive(1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            chk("stall_out_valid", 64'(out_valid), 64'(1));
            chk("stall_res", 64'(res_t'({sum, cout, ovf})), 64'(exp_q[0]));
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6 - STAGES; i++) begin
            drive(1'b1);
            #1;
            chk("resume_in_ready", 64'(in_ready), 64'(1));
            exp_q.push_back(model(a, b, cin));
            step();
        end
        in_valid = 1'b0;
        wait_got("stall_count", 6, 30);
        compare_all("stall_res_order", 1'b1);

        // ---- random bubbles and random backpressure ----
        got.delete();
        got_cyc.delete();
        exp_q.delete();
        n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            drive($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 3) != 0;
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin));
                n_acc++;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_got("rand_count", n_acc, 60);
        compare_all("rand_res", 1'b0);

        // ---- reset with results in flight ----
        got.delete();
        got_cyc.delete();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1);
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_sum", 64'(sum), 64'(0));
        chk("midrst_cout", 64'(cout), 64'(0));
        chk("midrst_ovf", 64'(ovf), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_rel_valid", 64'(out_valid), 64'(0));
        for (int i = 0; i < 2 * STAGES + 3; i++) step();
        chk("midrst_no_stale", 64'(got.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
